timing_generator: RTL and testbench

Master sequencer for the 4004 core: divides `sysclk` into the two-phase `clk1`/`clk2` clocks and steps the eight-subcycle instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3). It drives the phase-qualified strobes (`a12` … `x32`) consumed by the instruction pointer array, the instruction decoder and the register/ALU boards, plus SYNC. Adds run/halt/single-step control at instruction-cycle boundaries for debug.

---
 rtl/timing_generator_if.sv | 33 +++
 rtl/timing_generator.sv | 127 ++++++++++++
 tb/tb_timing_generator.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/timing_generator_if.sv
// Two-phase clock, subcycle strobe and run/step control bundle of the 4004 timing generator.
interface timing_generator_if;
  logic       run;
  logic       step;
  logic       clk1;
  logic       clk2;
  logic       a12;
  logic       a22;
  logic       a32;
  logic       m12;
  logic       m22;
  logic       x12;
  logic       x22;
  logic       x32;
  logic       sync;
  logic [2:0] subcycle;
  logic       cycle_end;
  logic       halted;

  // The generator side drives the clocks and strobes and receives debug control.
  modport master (
    input  run, step,
    output clk1, clk2, a12, a22, a32, m12, m22, x12, x22, x32,
    output sync, subcycle, cycle_end, halted
  );

  // Consumers of the timing plus the debug controller driving run/step.
  modport slave (
    output run, step,
    input  clk1, clk2, a12, a22, a32, m12, m22, x12, x22, x32,
    input  sync, subcycle, cycle_end, halted
  );
endinterface

// File: rtl/timing_generator.sv
// 4004 master sequencer: two-phase clock generation, eight-subcycle instruction
// cycle stepping and run/halt/single-step control at instruction boundaries.
module timing_generator #(
  parameter int unsigned PHASE_LEN = 17
) (
  input  logic                sysclk,
  input  logic                poc,
  timing_generator_if.master  tg
);

  localparam int unsigned CNT_W = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_LEN - 1);
  localparam logic [2:0] SUB_X3 = 3'd7;

  localparam logic [2:0] S_HALT = 3'd0;
  localparam logic [2:0] S_C1   = 3'd1;
  localparam logic [2:0] S_G1   = 3'd2;
  localparam logic [2:0] S_C2   = 3'd3;
  localparam logic [2:0] S_G2   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sub_q, sub_d;
  logic [7:0]       strobe_q, strobe_d;
  logic             clk1_q, clk1_d;
  logic             clk2_q, clk2_d;
  logic             sync_q, sync_d;
  logic             cycle_end_q, cycle_end_d;
  logic             halted_q, halted_d;

  // Next state plus next values of every registered output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;

    case (state_q)
      S_HALT: begin
        if (tg.run || tg.step) begin
          state_d = S_C1;
          sub_d   = 3'd0;
          cnt_d   = '0;
        end
      end
      S_C1, S_G1, S_C2, S_G2: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          case (state_q)
            S_C1:    state_d = S_G1;
            S_G1:    state_d = S_C2;
            S_C2:    state_d = S_G2;
            default: begin
              // End of G2: advance the subcycle or decide at the instruction boundary.
              if (sub_q != SUB_X3) begin
                sub_d   = sub_q + 3'd1;
                state_d = S_C1;
              end else if (tg.run) begin
                sub_d   = 3'd0;
                state_d = S_C1;
              end else begin
                state_d = S_HALT;
              end
            end
          endcase
        end
      end
      default: begin
        state_d = S_HALT;
        cnt_d   = '0;
      end
    endcase

    clk1_d      = (state_d == S_C1);
    clk2_d      = (state_d == S_C2);
    halted_d    = (state_d == S_HALT);
    sync_d      = (state_d != S_HALT) && (sub_d == SUB_X3);
    cycle_end_d = (state_d == S_G2) && (sub_d == SUB_X3) && (cnt_d == CNT_LAST);

    // A strobe moves only on entry to C2, so it spans C2/G2 of n and C1/G1 of n+1.
    strobe_d = strobe_q;
    if ((state_d == S_C2) && (state_q != S_C2)) begin
      strobe_d = 8'd1 << sub_d;
    end
  end

  always_ff @(posedge sysclk or posedge poc) begin
    if (poc) begin
      state_q     <= S_HALT;
      cnt_q       <= '0;
      sub_q       <= 3'd0;
      strobe_q    <= 8'd0;
      clk1_q      <= 1'b0;
      clk2_q      <= 1'b0;
      sync_q      <= 1'b0;
      cycle_end_q <= 1'b0;
      halted_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sub_q       <= sub_d;
      strobe_q    <= strobe_d;
      clk1_q      <= clk1_d;
      clk2_q      <= clk2_d;
      sync_q      <= sync_d;
      cycle_end_q <= cycle_end_d;
      halted_q    <= halted_d;
    end
  end

  assign tg.clk1      = clk1_q;
  assign tg.clk2      = clk2_q;
  assign tg.a12       = strobe_q[0];
  assign tg.a22       = strobe_q[1];
  assign tg.a32       = strobe_q[2];
  assign tg.m12       = strobe_q[3];
  assign tg.m22       = strobe_q[4];
  assign tg.x12       = strobe_q[5];
  assign tg.x22       = strobe_q[6];
  assign tg.x32       = strobe_q[7];
  assign tg.sync      = sync_q;
  assign tg.subcycle  = sub_q;
  assign tg.cycle_end = cycle_end_q;
  assign tg.halted    = halted_q;

endmodule

// File: tb/tb_timing_generator.sv
// Directed bench for timing_generator at PHASE_LEN 2, 3 and 1.
module tb_timing_generator;

  logic sysclk = 1'b0;
  logic poc1, poc2, poc3;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 sysclk = ~sysclk;

  timing_generator_if if1 ();
  timing_generator_if if2 ();
  timing_generator_if if3 ();

  timing_generator #(.PHASE_LEN(1)) u_p1 (.sysclk(sysclk), .poc(poc1), .tg(if1.master));
  timing_generator #(.PHASE_LEN(2)) u_p2 (.sysclk(sysclk), .poc(poc2), .tg(if2.master));
  timing_generator #(.PHASE_LEN(3)) u_p3 (.sysclk(sysclk), .poc(poc3), .tg(if3.master));

  logic [7:0] stb1, stb2, stb3;
  assign stb1 = {if1.x32, if1.x22, if1.x12, if1.m22, if1.m12, if1.a32, if1.a22, if1.a12};
  assign stb2 = {if2.x32, if2.x22, if2.x12, if2.m22, if2.m12, if2.a32, if2.a22, if2.a12};
  assign stb3 = {if3.x32, if3.x22, if3.x12, if3.m22, if3.m12, if3.a32, if3.a22, if3.a12};

  bit [255:0] c1_log, a12_log, x32_log, ce_log;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  function automatic int first_at(input bit [255:0] v, input int from, input bit val);
    for (int i = from; i < 256; i++) if (v[i] == val) return i;
    return -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, ce, hc, rises, ovl, noh, badwin, syncpos, synccnt, e1, e2, ec, es;
    logic prev;
    logic [7:0] pat;

    poc1 = 1'b1; poc2 = 1'b1; poc3 = 1'b1;
    if1.run = 1'b0; if1.step = 1'b0;
    if2.run = 1'b0; if2.step = 1'b0;
    if3.run = 1'b0; if3.step = 1'b0;
    repeat (3) tick();

    // Reset values
    check_eq("rst_clk1",      32'(if2.clk1), 0);
    check_eq("rst_clk2",      32'(if2.clk2), 0);
    check_eq("rst_strobes",   32'(stb2), 0);
    check_eq("rst_sync",      32'(if2.sync), 0);
    check_eq("rst_cycle_end", 32'(if2.cycle_end), 0);
    check_eq("rst_subcycle",  32'(if2.subcycle), 0);
    check_eq("rst_halted",    32'(if2.halted), 1);

    // Free run at PHASE_LEN=2
    if2.run = 1'b1;
    poc2 = 1'b0;
    for (int k = 0; k < 140; k++) begin
      tick();
      c1_log[k]  = if2.clk1;
      a12_log[k] = if2.a12;
      x32_log[k] = if2.x32;
      ce_log[k]  = if2.cycle_end;
      if (k == 0) begin
        check_eq("first_clk1",     32'(if2.clk1), 1);
        check_eq("first_subcycle", 32'(if2.subcycle), 0);
        check_eq("first_halted",   32'(if2.halted), 0);
      end
    end
    for (int s = 0; s < 16; s++) begin
      for (int j = 0; j < 8; j++) pat[7-j] = c1_log[8*s+j];
      check_eq("clk1_pattern", 32'(pat), 32'h0000_00C0);
    end
    check_eq("a12_rise",    first_at(a12_log, 0, 1'b1), 4);
    check_eq("x32_rise",    first_at(x32_log, 0, 1'b1), 60);
    check_eq("x32_fall",    first_at(x32_log, 60, 1'b0), 68);
    check_eq("cycle_end_1", first_at(ce_log, 0, 1'b1), 63);
    check_eq("cycle_end_2", first_at(ce_log, 64, 1'b1), 127);
    check_eq("cycle_end_3", first_at(ce_log, 128, 1'b1), -1);
    poc2 = 1'b1;

    // Strobe exclusivity over 10 instruction cycles at PHASE_LEN=3
    ovl = 0; noh = 0; badwin = 0; syncpos = 0; synccnt = 0; hc = 0;
    if3.run = 1'b1;
    poc3 = 1'b0;
    for (int k = 0; k < 960; k++) begin
      tick();
      if (if3.clk1 && if3.clk2) ovl++;
      if (k >= 6 && !$onehot(stb3)) noh++;
      if (k < 6 && stb3 != 8'd0) noh++;
      if (if3.sync !== ((k % 96) >= 84)) syncpos++;
      if (if3.sync) synccnt++;
      if (if3.halted) hc++;
      if ((k % 96) == 95) begin
        if (synccnt != 12) badwin++;
        synccnt = 0;
      end
      if (k == 6) check_eq("p3_a12_at_c2", 32'(stb3), 1);
    end
    check_eq("clk_overlap",    ovl, 0);
    check_eq("strobe_onehot",  noh, 0);
    check_eq("sync_12_per_96", badwin, 0);
    check_eq("sync_position",  syncpos, 0);
    check_eq("no_halt_in_run", hc, 0);

    // Drop run during M1: cycle completes then halts
    t = 0;
    while (if3.subcycle != 3'd3 && t < 200) begin tick(); t++; end
    check_eq("reach_m1", 32'(t < 200), 1);
    if3.run = 1'b0;
    t = 0; ce = 0;
    while (!if3.halted && t < 400) begin
      tick();
      if (if3.cycle_end) ce++;
      t++;
    end
    check_eq("halt_reached",   32'(t < 400), 1);
    check_eq("halt_one_end",   ce, 1);
    repeat (20) tick();
    check_eq("halt_halted",    32'(if3.halted), 1);
    check_eq("halt_strobes",   32'(stb3), 32'h80);
    check_eq("halt_clk1",      32'(if3.clk1), 0);
    check_eq("halt_clk2",      32'(if3.clk2), 0);
    check_eq("halt_sync",      32'(if3.sync), 0);
    check_eq("halt_subcycle",  32'(if3.subcycle), 7);

    // Single step: one instruction cycle then halt
    if3.step = 1'b1;
    tick();
    if3.step = 1'b0;
    check_eq("step_clk1",     32'(if3.clk1), 1);
    check_eq("step_halted",   32'(if3.halted), 0);
    check_eq("step_subcycle", 32'(if3.subcycle), 0);
    rises = 0; prev = if3.clk2;
    for (int k = 0; k < 120; k++) begin
      tick();
      if (if3.clk2 && !prev) rises++;
      prev = if3.clk2;
    end
    check_eq("step_clk2_pulses", rises, 8);
    check_eq("step_rehalt",      32'(if3.halted), 1);

    // Step pulsed mid-cycle is ignored
    if3.step = 1'b1;
    tick();
    if3.step = 1'b0;
    rises = 0; prev = if3.clk2;
    for (int k = 0; k < 150; k++) begin
      tick();
      if (k == 40) if3.step = 1'b1;
      if (k == 41) if3.step = 1'b0;
      if (if3.clk2 && !prev) rises++;
      prev = if3.clk2;
    end
    check_eq("midstep_clk2_pulses", rises, 8);
    check_eq("midstep_halted",      32'(if3.halted), 1);

    // Run and step together behave as run
    if3.run = 1'b1; if3.step = 1'b1;
    tick();
    if3.step = 1'b0;
    check_eq("both_clk1",   32'(if3.clk1), 1);
    check_eq("both_halted", 32'(if3.halted), 0);
    hc = 0; ce = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (if3.halted) hc++;
      if (if3.cycle_end) ce++;
    end
    check_eq("both_no_halt",   hc, 0);
    check_eq("both_cycle_end", ce, 2);

    // Asynchronous reset during C2 of X1
    t = 0;
    while (!(if3.subcycle == 3'd5 && if3.clk2) && t < 400) begin tick(); t++; end
    check_eq("reach_x1_c2", 32'(t < 400), 1);
    #2 poc3 = 1'b1;
    #1;
    check_eq("arst_clk1",      32'(if3.clk1), 0);
    check_eq("arst_clk2",      32'(if3.clk2), 0);
    check_eq("arst_strobes",   32'(stb3), 0);
    check_eq("arst_sync",      32'(if3.sync), 0);
    check_eq("arst_cycle_end", 32'(if3.cycle_end), 0);
    check_eq("arst_subcycle",  32'(if3.subcycle), 0);
    check_eq("arst_halted",    32'(if3.halted), 1);
    tick();
    poc3 = 1'b0;
    tick();
    check_eq("restart_clk1",     32'(if3.clk1), 1);
    check_eq("restart_subcycle", 32'(if3.subcycle), 0);
    check_eq("restart_strobes",  32'(stb3), 0);
    poc3 = 1'b1;

    // Boundary PHASE_LEN=1
    e1 = 0; e2 = 0; ec = 0; es = 0; noh = 0;
    if1.run = 1'b1;
    poc1 = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      x32_log[k] = if1.x32;
      if (if1.clk1 !== ((k % 4) == 0)) e1++;
      if (if1.clk2 !== ((k % 4) == 2)) e2++;
      if (if1.cycle_end !== ((k % 32) == 31)) ec++;
      if (int'(if1.subcycle) != ((k / 4) % 8)) es++;
      if (k >= 2 && !$onehot(stb1)) noh++;
    end
    check_eq("p1_clk1_period",  e1, 0);
    check_eq("p1_clk2_period",  e2, 0);
    check_eq("p1_cycle_end",    ec, 0);
    check_eq("p1_subcycle",     es, 0);
    check_eq("p1_onehot",       noh, 0);
    check_eq("p1_x32_rise",     first_at(x32_log, 0, 1'b1), 30);
    check_eq("p1_x32_fall",     first_at(x32_log, 30, 1'b0), 34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
